// File: rtl/channel_err_inj.sv
`default_nettype none
// ============================================================================
// channel_err_inj : 1-cycle symbol pipe that XORs burst and/or LFSR errors
// Rev 1.0
// ============================================================================
module channel_err_inj #(
  parameter int          WINDOW = 256,
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter int          CW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode_i,
  input  logic          start_i,
  input  logic [7:0]    gap_len_i,
  input  logic [7:0]    burst_len_i,
  input  logic [1:0]    err_mask_i,
  input  logic [7:0]    thresh_i,
  input  logic          valid_i,
  input  logic [1:0]    d_in,
  output logic          valid_o,
  output logic [1:0]    d_out,
  output logic [1:0]    err_o,
  output logic          busy_o,
  output logic [CW-1:0] word_ct_o,
  output logic [CW-1:0] bad_bit_ct_o
);

  localparam int             RW     = $clog2(WINDOW + 1);
  localparam logic [RW-1:0]  R_LAST = RW'(WINDOW - 1);
  localparam logic [15:0]    TAPS   = 16'hB400;

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_BURST, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      g_q, g_d, b_q, b_d;
  logic [RW-1:0]   r_q, r_d;
  logic [7:0]      gap_q, burst_q;
  logic [1:0]      mask_q;
  logic [15:0]     lfsr_q, lfsr_step;
  logic            valid_q, busy_q;
  logic [1:0]      dout_q, err_q;
  logic [CW-1:0]   word_q, bad_q, bad_d, pop;
  logic [CW:0]     bad_sum;
  logic            active;
  logic [1:0]      rnd, e;

  always_comb begin
    active    = valid_i && !start_i && (state_q == S_GAP || state_q == S_BURST);
    rnd       = {lfsr_q[15:8] < thresh_i, lfsr_q[7:0] < thresh_i};
    lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    e = 2'b00;
    if (active) begin
      if (mode_i[0] && state_q == S_BURST) e = e | mask_q;
      if (mode_i[1])                       e = e | rnd;
    end
    pop     = CW'(e[0]) + CW'(e[1]);
    bad_sum = {1'b0, bad_q} + {1'b0, pop};
    bad_d   = bad_sum[CW] ? {CW{1'b1}} : bad_sum[CW-1:0];

    state_d = state_q;
    g_d     = g_q;
    b_d     = b_q;
    r_d     = r_q;
    if (start_i) begin
      // A zero gap means the very first armed symbol is already a burst symbol.
      state_d = (gap_len_i == 8'd0 && burst_len_i != 8'd0) ? S_BURST : S_GAP;
      g_d = 8'd0;
      b_d = 8'd0;
      r_d = '0;
    end else if (active) begin
      r_d = r_q + 1'b1;
      if (state_q == S_GAP) begin
        if (g_q == gap_q - 8'd1) begin
          g_d = 8'd0;
          if (burst_q != 8'd0) state_d = S_BURST;
        end else begin
          g_d = g_q + 8'd1;
        end
      end else begin
        if (b_q == burst_q - 8'd1) begin
          b_d     = 8'd0;
          g_d     = 8'd0;
          state_d = (gap_q == 8'd0) ? S_BURST : S_GAP;
        end else begin
          b_d = b_q + 8'd1;
        end
      end
      if (r_q == R_LAST) state_d = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      g_q     <= 8'd0;
      b_q     <= 8'd0;
      r_q     <= '0;
      gap_q   <= 8'd0;
      burst_q <= 8'd0;
      mask_q  <= 2'b00;
      lfsr_q  <= SEED;
      valid_q <= 1'b0;
      dout_q  <= 2'b00;
      err_q   <= 2'b00;
      busy_q  <= 1'b0;
      word_q  <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      b_q     <= b_d;
      r_q     <= r_d;
      busy_q  <= (state_d == S_GAP || state_d == S_BURST);
      valid_q <= valid_i;
      if (valid_i) begin
        dout_q <= d_in ^ e;
        err_q  <= e;
      end
      if (start_i) begin
        gap_q   <= gap_len_i;
        burst_q <= burst_len_i;
        mask_q  <= err_mask_i;
        lfsr_q  <= SEED;
        word_q  <= '0;
        bad_q   <= '0;
      end else if (active) begin
        lfsr_q  <= lfsr_step;
        word_q  <= word_q + 1'b1;
        bad_q   <= bad_d;
      end
    end
  end

  assign valid_o      = valid_q;
  assign d_out        = dout_q;
  assign err_o        = err_q;
  assign busy_o       = busy_q;
  assign word_ct_o    = word_q;
  assign bad_bit_ct_o = bad_q;

endmodule
`default_nettype wire

// File: tb/tb_channel_err_inj.sv
`default_nettype none
// ============================================================================
// tb_channel_err_inj : scoreboard bench for channel_err_inj
// Rev 1.0
// ============================================================================
module tb_channel_err_inj;

  localparam int          WINDOW = 256;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam int          CW     = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    mode_i = 2'b00;
  logic          start_i = 1'b0;
  logic [7:0]    gap_len_i = 8'd0, burst_len_i = 8'd0, thresh_i = 8'd0;
  logic [1:0]    err_mask_i = 2'b00;
  logic          valid_i = 1'b0;
  logic [1:0]    d_in = 2'b00;
  logic          valid_o, busy_o;
  logic [1:0]    d_out, err_o;
  logic [CW-1:0] word_ct_o, bad_bit_ct_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_q[$];

  // reference model state
  bit          armed = 0;
  int          k = 0;
  int          exp_bad = 0;
  logic [15:0] m_lfsr = SEED;
  int          m_gap = 0, m_burst = 0;
  logic [1:0]  m_mask = 2'b00;

  channel_err_inj #(.WINDOW(WINDOW), .SEED(SEED), .CW(CW)) dut (
    .clk(clk), .rst(rst), .mode_i(mode_i), .start_i(start_i),
    .gap_len_i(gap_len_i), .burst_len_i(burst_len_i), .err_mask_i(err_mask_i),
    .thresh_i(thresh_i), .valid_i(valid_i), .d_in(d_in), .valid_o(valid_o),
    .d_out(d_out), .err_o(err_o), .busy_o(busy_o), .word_ct_o(word_ct_o),
    .bad_bit_ct_o(bad_bit_ct_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic bit in_burst(input int idx);
    if (m_burst == 0) return 1'b0;
    return (idx % (m_gap + m_burst)) >= m_gap;
  endfunction

  // Scoreboard monitor: every emitted symbol must match the oldest expectation.
  always @(negedge clk) begin
    if (valid_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_symbol: got d_out=%b err_o=%b with empty queue", d_out, err_o);
      end else begin
        logic [3:0] x;
        x = exp_q.pop_front();
        check("sym_d_out", int'(d_out), int'(x[3:2]));
        check("sym_err_o", int'(err_o), int'(x[1:0]));
      end
    end
  end

  task automatic sym(input bit v, input logic [1:0] d, input bit st);
    logic [1:0] e;
    valid_i = v;
    d_in    = d;
    start_i = st;
    if (st) begin
      armed = 1; k = 0; exp_bad = 0; m_lfsr = SEED;
      m_gap = int'(gap_len_i); m_burst = int'(burst_len_i); m_mask = err_mask_i;
    end
    if (v) begin
      e = 2'b00;
      if (!st && armed && k < WINDOW) begin
        if (mode_i[0] && in_burst(k)) e = e | m_mask;
        if (mode_i[1]) e = e | {m_lfsr[15:8] < thresh_i, m_lfsr[7:0] < thresh_i};
        m_lfsr  = lfsr_next(m_lfsr);
        exp_bad = exp_bad + int'(e[0]) + int'(e[1]);
        k++;
      end
      exp_q.push_back({d ^ e, e});
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    valid_i = 1'b0;
  endtask

  task automatic do_reset(input bit v);
    rst = 1'b0; valid_i = v; d_in = 2'b10;
    @(posedge clk); #1;
    rst = 1'b1; valid_i = 1'b0;
    armed = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid_o"}, int'(valid_o), 0);
    check({tag, "_d_out"},   int'(d_out), 0);
    check({tag, "_err_o"},   int'(err_o), 0);
    check({tag, "_busy_o"},  int'(busy_o), 0);
    check({tag, "_word"},    int'(word_ct_o), 0);
    check({tag, "_bad"},     int'(bad_bit_ct_o), 0);
  endtask

  task automatic setup(input logic [1:0] m, input int g, input int b,
                       input logic [1:0] mk, input int th);
    mode_i = m; gap_len_i = 8'(g); burst_len_i = 8'(b);
    err_mask_i = mk; thresh_i = 8'(th);
  endtask

  initial begin
    logic [1:0] r2;
    @(posedge clk); #1;
    do_reset(1'b0);
    check_zero("reset");

    // 1: pass-through mode
    setup(2'b00, 4, 2, 2'b11, 255);
    sym(1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 300; i++) begin
      r2 = 2'($urandom_range(0, 3));
      sym(1'b1, r2, 1'b0);
    end
    idle(1);
    check("t1_bad", int'(bad_bit_ct_o), 0);
    check("t1_word", int'(word_ct_o), 256);
    check("t1_busy", int'(busy_o), 0);

    // 2: periodic bursts gap=4 burst=2
    setup(2'b01, 4, 2, 2'b11, 0);
    sym(1'b0, 2'b00, 1'b1);
    check("t2_busy", int'(busy_o), 1);
    for (int i = 0; i < 20; i++) sym(1'b1, 2'(i), 1'b0);
    idle(1);
    check("t2_bad", int'(bad_bit_ct_o), 12);
    check("t2_word", int'(word_ct_o), 20);

    // 3: back-to-back single-symbol bursts until the window closes
    setup(2'b01, 0, 1, 2'b01, 0);
    sym(1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 300; i++) sym(1'b1, 2'(i * 3), 1'b0);
    idle(1);
    check("t3_bad", int'(bad_bit_ct_o), 256);
    check("t3_word", int'(word_ct_o), 256);
    check("t3_busy", int'(busy_o), 0);

    // 4: random errors, threshold 0 then 255
    setup(2'b10, 4, 2, 2'b11, 0);
    sym(1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 20; i++) sym(1'b1, 2'(i), 1'b0);
    idle(1);
    check("t4a_bad", int'(bad_bit_ct_o), 0);
    thresh_i = 8'd255;
    sym(1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 40; i++) sym(1'b1, 2'(i + 1), 1'b0);
    idle(1);
    check("t4b_bad", int'(bad_bit_ct_o), exp_bad);
    check("t4b_word", int'(word_ct_o), 40);

    // 5: valid one cycle in three
    setup(2'b01, 4, 2, 2'b11, 0);
    sym(1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 20; i++) begin
      sym(1'b1, 2'(i), 1'b0);
      sym(1'b0, 2'b11, 1'b0);
      sym(1'b0, 2'b01, 1'b0);
    end
    idle(1);
    check("t5_bad", int'(bad_bit_ct_o), 12);
    check("t5_word", int'(word_ct_o), 20);

    // 6: reset mid-burst, then restart with a valid symbol in the start cycle
    setup(2'b01, 4, 2, 2'b11, 0);
    sym(1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 5; i++) sym(1'b1, 2'(i), 1'b0);
    do_reset(1'b1);
    check_zero("t6_reset");
    sym(1'b1, 2'b11, 1'b1);
    check("t6_start_word", int'(word_ct_o), 0);
    for (int i = 0; i < 6; i++) sym(1'b1, 2'b00, 1'b0);
    idle(1);
    check("t6_bad", int'(bad_bit_ct_o), 4);
    check("t6_word", int'(word_ct_o), 6);
    check("t6_busy", int'(busy_o), 1);

    idle(2);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
